// File: rtl/stf_detect_pkg.sv
// Shared widths, delay depth and FSM encoding for the STF detector.
package stf_detect_pkg;
   localparam int SAMP_W    = 16;
   localparam int PROD_W    = 33;
   localparam int SUM_W     = 37;
   localparam int PWR_W     = 36;
   localparam int MAG_W     = 38;
   localparam int EN_W      = 32;
   localparam int CMP_W     = 44;
   localparam int DLY_DEPTH = 16;

   typedef enum logic [1:0] {FILL, SEARCH, HOLD} state_t;

   // Most-negative input maps to 2^(SUM_W-1), which is the correct unsigned magnitude.
   function automatic logic [SUM_W-1:0] abs_sum(input logic signed [SUM_W-1:0] v);
      return v[SUM_W-1] ? SUM_W'(-v) : SUM_W'(v);
   endfunction
endpackage

// File: rtl/stf_mov_sum.sv
// Exact moving sum over the last DEPTH enabled inputs (add newest, drop oldest).
module stf_mov_sum #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             rstn,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sum
);
   logic [DEPTH-1:0][WIDTH-1:0] hist;

   always_ff @(posedge clock) begin
      if (!rstn || clear) begin
         hist <= '0;
         sum  <= '0;
      end else if (en) begin
         hist <= {hist[DEPTH-2:0], din};
         sum  <= sum + din - hist[DEPTH-1];
      end
   end
endmodule

// File: rtl/stf_detect.sv
// Legacy short-preamble detector: delay-16 autocorrelation against windowed power.
// Define STF_DETECT_PHASE_EN to hold the correlation re/im captured at each detection.
module stf_detect
   import stf_detect_pkg::*;
#(
   parameter int               THRESH_NUM  = 12,
   parameter int               MIN_PLATEAU = 48,
   parameter int               HOLDOFF     = 160,
   parameter logic [PWR_W-1:0] POWER_MIN   = 36'd4096
) (
   input  logic                    clock,
   input  logic                    rstn,
   input  logic                    clear,
   input  logic [2*SAMP_W-1:0]     sample_in,
   input  logic                    sample_in_strobe,
   output logic                    metric_strobe,
   output logic [MAG_W-1:0]        corr_mag,
   output logic [PWR_W-1:0]        power_sum,
   output logic                    stf_detected,
   output logic signed [SUM_W-1:0] corr_re_latched,
   output logic signed [SUM_W-1:0] corr_im_latched
);
   localparam int STAGES = 3;
   localparam int PLAT_W = $clog2(MIN_PLATEAU + 1);
   localparam int HOLD_W = $clog2(HOLDOFF + 1);

   logic                                flush;
   logic [STAGES:1]                     vld_pipe;
   logic [DLY_DEPTH-1:0][2*SAMP_W-1:0]  dly;
   logic signed [SAMP_W-1:0]            si, sq, di, dq;
   logic signed [PROD_W-1:0]            p_re, p_im, p_re_q, p_im_q;
   logic signed [EN_W-1:0]              ii, qq;
   logic [EN_W-1:0]                     e, e_q;
   logic [SUM_W-1:0]                    sum_re, sum_im;
   logic [PWR_W-1:0]                    sum_pw;
   logic [MAG_W-1:0]                    mag;
   logic [CMP_W-1:0]                    cmp_lhs, cmp_rhs;
   logic                                full, above, det_now;
   state_t                              state;
   logic [5:0]                          samp_cnt;
   logic [PLAT_W-1:0]                   plat_cnt;
   logic [HOLD_W-1:0]                   hold_cnt;

   assign flush = !rstn || clear;
   assign si = sample_in[31:16];
   assign sq = sample_in[15:0];
   assign di = dly[DLY_DEPTH-1][31:16];
   assign dq = dly[DLY_DEPTH-1][15:0];

   always_comb begin
      p_re = PROD_W'(si) * PROD_W'(di) + PROD_W'(sq) * PROD_W'(dq);
      p_im = PROD_W'(sq) * PROD_W'(di) - PROD_W'(si) * PROD_W'(dq);
      ii   = EN_W'(si) * EN_W'(si);
      qq   = EN_W'(sq) * EN_W'(sq);
      e    = $unsigned(ii) + $unsigned(qq);
   end

   // Stage 1: delay line and per-sample products.
   always_ff @(posedge clock) begin
      if (flush) begin
         vld_pipe <= '0;
         dly      <= '0;
         p_re_q   <= '0;
         p_im_q   <= '0;
         e_q      <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], sample_in_strobe};
         if (sample_in_strobe) begin
            dly    <= {dly[DLY_DEPTH-2:0], sample_in};
            p_re_q <= p_re;
            p_im_q <= p_im;
            e_q    <= e;
         end
      end
   end

   // Stage 2: windowed sums.
   stf_mov_sum #(.WIDTH(SUM_W), .DEPTH(DLY_DEPTH)) u_sum_re (
      .clock(clock), .rstn(rstn), .clear(clear), .en(vld_pipe[1]),
      .din(SUM_W'(p_re_q)), .sum(sum_re));
   stf_mov_sum #(.WIDTH(SUM_W), .DEPTH(DLY_DEPTH)) u_sum_im (
      .clock(clock), .rstn(rstn), .clear(clear), .en(vld_pipe[1]),
      .din(SUM_W'(p_im_q)), .sum(sum_im));
   stf_mov_sum #(.WIDTH(PWR_W), .DEPTH(DLY_DEPTH)) u_sum_pw (
      .clock(clock), .rstn(rstn), .clear(clear), .en(vld_pipe[1]),
      .din(PWR_W'(e_q)), .sum(sum_pw));

   always_comb begin
      mag     = MAG_W'(abs_sum(sum_re)) + MAG_W'(abs_sum(sum_im));
      cmp_lhs = CMP_W'(mag) << 4;
      cmp_rhs = CMP_W'(sum_pw) * CMP_W'(THRESH_NUM);
      full    = samp_cnt >= 6'd31;
      above   = full && (cmp_lhs > cmp_rhs) && (sum_pw >= POWER_MIN);
      det_now = vld_pipe[2] && (state != HOLD) && above &&
                (plat_cnt == PLAT_W'(MIN_PLATEAU - 1));
   end

   assign metric_strobe = vld_pipe[3];

   // Stage 3: registered metric plus FSM; the pulse lines up with metric_strobe.
   always_ff @(posedge clock) begin
      if (flush) begin
         state        <= FILL;
         samp_cnt     <= '0;
         plat_cnt     <= '0;
         hold_cnt     <= '0;
         stf_detected <= 1'b0;
         corr_mag     <= '0;
         power_sum    <= '0;
      end else begin
         stf_detected <= det_now;
         if (vld_pipe[2]) begin
            corr_mag  <= mag;
            power_sum <= sum_pw;
            if (samp_cnt != 6'd32) samp_cnt <= samp_cnt + 6'd1;
            unique case (state)
               FILL, SEARCH: begin
                  if (full) state <= SEARCH;
                  if (det_now) begin
                     plat_cnt <= '0;
                     hold_cnt <= '0;
                     state    <= HOLD;
                  end else if (above) begin
                     plat_cnt <= plat_cnt + PLAT_W'(1);
                  end else begin
                     plat_cnt <= '0;
                  end
               end
               HOLD: begin
                  if (hold_cnt == HOLD_W'(HOLDOFF - 1)) begin
                     state    <= SEARCH;
                     plat_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
               default: state <= FILL;
            endcase
         end
      end
   end

`ifdef STF_DETECT_PHASE_EN
   logic signed [SUM_W-1:0] lat_re, lat_im;

   always_ff @(posedge clock) begin
      if (flush) begin
         lat_re <= '0;
         lat_im <= '0;
      end else if (det_now) begin
         lat_re <= sum_re;
         lat_im <= sum_im;
      end
   end

   assign corr_re_latched = lat_re;
   assign corr_im_latched = lat_im;
`else
   assign corr_re_latched = '0;
   assign corr_im_latched = '0;
`endif
endmodule

// File: tb/tb_stf_detect.sv
// Directed STF/noise scenarios with random gaps and filler data, checked every cycle against
// a sample-indexed correlation model. Define STF_DETECT_PHASE_EN to check the latched re/im.
`timescale 1ns/1ps
module tb_stf_detect;
   logic               clock = 1'b0;
   logic               rstn, clear, sample_in_strobe;
   logic [31:0]        sample_in;
   logic               metric_strobe, stf_detected;
   logic [37:0]        corr_mag;
   logic [35:0]        power_sum;
   logic signed [36:0] corr_re_latched, corr_im_latched;

   int vectors = 0;
   int errors  = 0;

   stf_detect dut (
      .clock(clock), .rstn(rstn), .clear(clear),
      .sample_in(sample_in), .sample_in_strobe(sample_in_strobe),
      .metric_strobe(metric_strobe), .corr_mag(corr_mag), .power_sum(power_sum),
      .stf_detected(stf_detected),
      .corr_re_latched(corr_re_latched), .corr_im_latched(corr_im_latched));

   always #5 clock = ~clock;

   typedef struct {
      bit     vld;
      bit     det;
      longint re, im, mag, pwr;
      int     n;
   } ev_t;

   localparam int STF_I [16] = '{754, -1066, 1066, 754, -754, 1066, -1066, -754,
                                 754, 754, -1066, 1066, -754, -754, 1066, 754};
   localparam int STF_Q [16] = '{754, 754, -1066, -754, 1066, -754, -754, 1066,
                                 754, -1066, -754, 754, 1066, -1066, -754, 1066};

   ev_t    pipe [3];
   int     xi[$], xq[$];
   int     run_len, hold_left;
   longint cur_mag, cur_pwr, cur_re, cur_im, lat_re_ref, lat_im_ref;
   int     det_list[$];

   task automatic chk(input string tag, input logic signed [63:0] got, input longint exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      xi.delete();
      xq.delete();
      run_len   = 0;
      hold_left = 0;
      for (int k = 0; k < 3; k++) begin
         pipe[k]   = '{default: 0};
         pipe[k].n = -1;
      end
      cur_mag = 0; cur_pwr = 0; cur_re = 0; cur_im = 0;
   endtask

   // Correlation and power recomputed from scratch over the window ending at sample n.
   task automatic model_step(input logic [31:0] s, output ev_t ev);
      int n;
      bit above;
      ev = '{default: 0};
      xi.push_back(int'($signed(s[31:16])));
      xq.push_back(int'($signed(s[15:0])));
      n = xi.size() - 1;
      for (int k = n - 15; k <= n; k++) begin
         if (k < 0) continue;
         ev.pwr += longint'(xi[k]) * xi[k] + longint'(xq[k]) * xq[k];
         if (k >= 16) begin
            ev.re += longint'(xi[k]) * xi[k-16] + longint'(xq[k]) * xq[k-16];
            ev.im += longint'(xq[k]) * xi[k-16] - longint'(xi[k]) * xq[k-16];
         end
      end
      ev.mag = (ev.re < 0 ? -ev.re : ev.re) + (ev.im < 0 ? -ev.im : ev.im);
      above  = (n >= 31) && (ev.mag * 16 > ev.pwr * 12) && (ev.pwr >= 4096);
      ev.vld = 1'b1;
      ev.n   = n;
      if (hold_left > 0) begin
         hold_left--;
         run_len = 0;
      end else if (above) begin
         run_len++;
         if (run_len == 48) begin
            ev.det    = 1'b1;
            run_len   = 0;
            hold_left = 160;
         end
      end else begin
         run_len = 0;
      end
   endtask

   task automatic tick(input bit stb, input logic [31:0] s, input bit clr, input bit rst);
      ev_t ev;
      rstn = !rst; clear = clr; sample_in_strobe = stb; sample_in = s;
      @(posedge clock);
      if (rst || clr) begin
         model_reset();
      end else begin
         ev   = '{default: 0};
         ev.n = -1;
         if (stb) model_step(s, ev);
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = ev;
         if (pipe[2].vld) begin
            cur_mag = pipe[2].mag;
            cur_pwr = pipe[2].pwr;
         end
         if (pipe[2].vld && pipe[2].det) begin
            lat_re_ref = pipe[2].re;
            lat_im_ref = pipe[2].im;
`ifdef STF_DETECT_PHASE_EN
            cur_re = pipe[2].re;
            cur_im = pipe[2].im;
`endif
         end
      end
      @(negedge clock);
      chk("metric_strobe", metric_strobe, pipe[2].vld);
      chk("stf_detected", stf_detected, pipe[2].vld && pipe[2].det);
      chk("corr_mag", corr_mag, cur_mag);
      chk("power_sum", power_sum, cur_pwr);
      chk("corr_re_latched", corr_re_latched, cur_re);
      chk("corr_im_latched", corr_im_latched, cur_im);
      if (stf_detected === 1'b1) det_list.push_back(pipe[2].n);
   endtask

   function automatic logic [31:0] pack(input int i, input int q);
      return {16'(i), 16'(q)};
   endfunction

   function automatic logic [31:0] stf(input int j, input int sh);
      return pack(STF_I[j % 16] >>> sh, STF_Q[j % 16] >>> sh);
   endfunction

   task automatic send(input logic [31:0] s, input int gap);
      tick(1'b1, s, 1'b0, 1'b0);
      repeat (gap) tick(1'b0, $urandom, 1'b0, 1'b0);
   endtask

   task automatic start();
      tick(1'b0, $urandom, 1'b0, 1'b1);
      det_list.delete();
   endtask

   task automatic drain();
      repeat (4) tick(1'b0, $urandom, 1'b0, 1'b0);
   endtask

   function automatic int det_at(input int k);
      return (det_list.size() > k) ? det_list[k] : -1;
   endfunction

   initial begin
      longint stf_pwr;
      real    th, ri, rq;
      rstn = 1'b0; clear = 1'b0; sample_in_strobe = 1'b0; sample_in = '0;
      model_reset();
      lat_re_ref = 0; lat_im_ref = 0;
      stf_pwr = 0;
      for (int j = 0; j < 16; j++)
         stf_pwr += longint'(STF_I[j]) * STF_I[j] + longint'(STF_Q[j]) * STF_Q[j];

      // Reset state
      start();
      chk("reset_metric_strobe", metric_strobe, 0);
      chk("reset_corr_mag", corr_mag, 0);

      // All-zero input
      start();
      for (int j = 0; j < 500; j++) send('0, 0);
      drain();
      chk("zero_det_count", det_list.size(), 0);
      chk("zero_power", power_sum, 0);

      // 160 STF samples back to back
      start();
      for (int j = 0; j < 160; j++) send(stf(j, 0), 0);
      drain();
      chk("stf160_det_count", det_list.size(), 1);
      chk("stf160_det_n", det_at(0), 78);
      chk("stf160_power_const", power_sum, stf_pwr);

      // Continuous STF: re-arm after holdoff
      start();
      for (int j = 0; j < 400; j++) send(stf(j, 0), 0);
      drain();
      chk("stf400_det_count", det_list.size(), 2);
      chk("stf400_det0_n", det_at(0), 78);
      chk("stf400_det1_n", det_at(1), 286);

      // Strobe every 4th cycle
      start();
      for (int j = 0; j < 160; j++) send(stf(j, 0), 3);
      drain();
      chk("gap4_det_count", det_list.size(), 1);
      chk("gap4_det_n", det_at(0), 78);

      // Under-powered STF
      start();
      for (int j = 0; j < 160; j++) send(stf(j, 8), $urandom_range(0, 1));
      drain();
      chk("weak_det_count", det_list.size(), 0);

      // Random noise +-0x0100 with random gaps
      start();
      for (int j = 0; j < 1000; j++)
         send(pack(int'($urandom_range(0, 512)) - 256, int'($urandom_range(0, 512)) - 256),
              $urandom_range(0, 2));
      drain();
      chk("noise_det_count", det_list.size(), 0);

      // Clear mid-plateau, same-cycle strobe dropped
      start();
      for (int j = 0; j < 60; j++) send(stf(j, 0), 0);
      tick(1'b1, stf(60, 0), 1'b1, 1'b0);
      chk("clr_pre_det_count", det_list.size(), 0);
      for (int j = 61; j < 161; j++) send(stf(j, 0), 0);
      drain();
      chk("clr_det_count", det_list.size(), 1);
      chk("clr_det_n", det_at(0), 78);

      // Same with rstn
      start();
      for (int j = 0; j < 60; j++) send(stf(j, 0), $urandom_range(0, 1));
      tick(1'b1, stf(60, 0), 1'b0, 1'b1);
      chk("rst_pre_det_count", det_list.size(), 0);
      for (int j = 61; j < 161; j++) send(stf(j, 0), $urandom_range(0, 1));
      drain();
      chk("rst_det_count", det_list.size(), 1);
      chk("rst_det_n", det_at(0), 78);

      // Phase-rotated STF
      start();
      th = 6.283185307179586 / 200.0;
      for (int j = 0; j < 160; j++) begin
         ri = STF_I[j % 16] * $cos(th * j) - STF_Q[j % 16] * $sin(th * j);
         rq = STF_I[j % 16] * $sin(th * j) + STF_Q[j % 16] * $cos(th * j);
         send(pack(int'(ri), int'(rq)), $urandom_range(0, 2));
      end
      drain();
      chk("rot_det_count", det_list.size(), 1);
      chk("rot_det_n", det_at(0), 78);
`ifdef STF_DETECT_PHASE_EN
      chk("rot_lat_re", corr_re_latched, lat_re_ref);
      chk("rot_lat_im", corr_im_latched, lat_im_ref);
`else
      chk("rot_lat_re", corr_re_latched, 0);
      chk("rot_lat_im", corr_im_latched, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/stf_detect.md
Name: stf_detect

Overview:
- RX-side counterpart of the TX short-training-field generator. Finds the 802.11 legacy short preamble in the baseband sample stream.
- Method: delay-16 autocorrelation against a windowed power estimate.
- Emits a one-cycle detection pulse once the normalised correlation stays above threshold for a plateau of samples.
- Sits between the RX front-end sample stream and coarse CFO/long-preamble sync.

Parameters:
- THRESH_NUM, 12: threshold numerator in sixteenths; 12 = 0.75 normalised correlation.
- MIN_PLATEAU, 48: consecutive above-threshold metric samples required to declare detection.
- HOLDOFF, 160: metric samples ignored after a detection before re-arming.
- POWER_MIN, 36'd4096: minimum windowed power sum for a metric sample to qualify.

Ports:
- clock  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- clear  in  1  synchronous restart: flush state, same effect as reset.
- sample_in  in  32  [31:16] I, [15:0] Q, signed 16-bit each; same packing as TX STF words.
- sample_in_strobe  in  1  sample_in valid this cycle.
- metric_strobe  out  1  corr_mag/power_sum valid.
- corr_mag  out  38  |Re|+|Im| of the correlation sum, unsigned.
- power_sum  out  36  windowed power, unsigned.
- stf_detected  out  1  one-cycle detection pulse.
- corr_re_latched  out  37  correlation real part at detection, signed.
- corr_im_latched  out  37  correlation imaginary part at detection, signed.

Behaviour:
- Reset (rstn=0 at clock edge) or clear=1: all outputs 0; delay line and moving sums zeroed; counters 0; FSM to FILL. Reset mid-plateau discards progress.
- Datapath processing: on each strobe, x[n] = sample_in.
  - Product p = x[n]·conj(x[n-16]): p_re = I·Id + Q·Qd, p_im = Q·Id − I·Qd, each 33-bit signed, full precision.
  - Power e = I² + Q², 32-bit unsigned.
  - Moving sums over the last 16 p and e: 37-bit signed (re/im) and 36-bit unsigned, exact (add newest, subtract oldest).
  - Magnitude corr_mag = |re|+|im|, 38-bit.
- Pipeline: 3 registered stages, each advancing only when its valid bit is set; no backpressure.
  - metric_strobe asserts exactly 3 clocks after the sample_in_strobe that produced it.
  - Strobe gaps of any length are allowed; results depend on sample index only.
- Qualification: above = (corr_mag·16 > power_sum·THRESH_NUM) AND (power_sum ≥ POWER_MIN). Compare at 44 bits, no truncation.
- Sample counter saturates at 32.
  - Metrics for samples 0..30 (windows not full) are output but never qualify.
  - Sample 31 is the first qualifying candidate.
- FSM, advancing on metric_strobe only:
  - FILL → SEARCH when the sample counter reaches 31.
  - SEARCH: above increments plateau_cnt; otherwise plateau_cnt=0.
    - When plateau_cnt reaches MIN_PLATEAU: assert stf_detected in the same cycle as that metric_strobe, latch corr re/im, set hold_cnt=0, go to HOLD.
  - HOLD: count HOLDOFF metric samples ignoring qualification, then go to SEARCH with plateau_cnt=0.
- Simultaneous clear and strobe: clear wins and the sample is dropped.

Optional Feature:
STF_DETECT_PHASE_EN:
- Defined: corr_re_latched/corr_im_latched are captured on each stf_detected and held until the next detection, reset, or clear. They feed the coarse CFO estimator.
- Undefined: both ports are tied to 0 and no latch registers are synthesised.
- All other behaviour is identical either way.

Decomposition:
- Package stf_detect_pkg holds:
  - sample/product/sum/magnitude width localparams (16/33/37/36/38);
  - delay depth 16;
  - FSM state enum {FILL, SEARCH, HOLD}.
- One sub-module, stf_mov_sum: a parameterised (WIDTH, DEPTH=16) exact moving-sum with shift register. It is instantiated three times (p_re, p_im, e).

Test Plan:
- All-zero input, 500 strobes every cycle → stf_detected never asserts; corr_mag=0, power_sum=0.
- Repeating 16-sample TX STF table (±0x02F2/±0x042A pattern), 160 samples, strobe every cycle:
  - exactly one stf_detected, 3 clocks after the strobe of sample 78;
  - power_sum constant from sample 31 onward.
- Continuous STF, 400 samples → detections after samples 78 and 286 only.
- Same STF with strobe every 4th cycle → detection after sample 78; pulse 3 clocks after that strobe, lasting 1 cycle.
- STF scaled so power_sum < POWER_MIN, or LFSR noise ±0x0100 for 1000 samples → no detection.
- Clear asserted at sample 60 of STF, stream continues → no detection until sample 78 after the clear. Repeat using rstn instead of clear.
- With STF_DETECT_PHASE_EN and STF rotated by a fixed phase step per sample → latched re/im equal to the reference-model correlation sum at sample 78. Without the macro → both latched ports read 0.
